core_seq_ctrl: RTL and testbench

//  Instruction sequencer sitting directly upstream of core. After a start pulse it emits the 34-bit inst word, mode and sel

---
 rtl/core_seq_pkg.sv | 34 +++
 rtl/seq_cnt.sv | 39 +++
 rtl/core_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared definitions for the conv-layer instruction sequencer.
// Instruction bit positions, idle word and FSM state encoding.
package core_seq_pkg;

  localparam int INST_W = 34;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_LD,
    S_A_RD,
    S_A_EX,
    S_DRAIN,
    S_O_WR,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/seq_cnt.sv
// Loadable up-counter with terminal-count flag.
// Used for phase step, kernel index and drain timeout.
module seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/core_seq_ctrl.sv
// Conv-layer instruction sequencer: weight load, execute and
// ofifo drain per kernel index, all outputs registered.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int ROW      = 2,
  parameter int COL      = 2,
  parameter int W_BASE   = 0,
  parameter int A_BASE   = 1024,
  parameter int O_BASE   = 0,
  parameter int DRAIN_TO = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_nij,
  input  logic [3:0]        cfg_kij,
  input  logic              cfg_mode,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              mode,
  output logic              sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        kij_idx
);

  localparam int SW = ADDR_W + 1;
  localparam int TW = $clog2(DRAIN_TO + 1);

  state_e              state_q, state_d;
  logic                gap_q, gap_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                mode_q, mode_d;
  logic                sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   nij_q, nij_d;
  logic [3:0]          nkij_q, nkij_d;

  logic          step_ld, step_en, step_tc;
  logic [SW-1:0] step_last, step_cnt;
  logic          kij_ld, kij_en, kij_tc;
  logic [3:0]    kij_cnt;
  logic          to_ld, to_en, to_tc;
  logic [TW-1:0] to_cnt;
  logic          to_cnt_unused;

  logic [SW-1:0]     nij_ext;
  logic [ADDR_W-1:0] w_addr, a_addr, o_addr;

  seq_cnt #(.W(SW)) u_step (
    .clk    (clk),
    .reset  (reset),
    .ld     (step_ld),
    .en     (step_en),
    .ld_val ('0),
    .last   (step_last),
    .cnt    (step_cnt),
    .tc     (step_tc)
  );

  seq_cnt #(.W(4)) u_kij (
    .clk    (clk),
    .reset  (reset),
    .ld     (kij_ld),
    .en     (kij_en),
    .ld_val (4'd0),
    .last   (nkij_q - 4'd1),
    .cnt    (kij_cnt),
    .tc     (kij_tc)
  );

  seq_cnt #(.W(TW)) u_to (
    .clk    (clk),
    .reset  (reset),
    .ld     (to_ld),
    .en     (to_en),
    .ld_val ('0),
    .last   (TW'(DRAIN_TO - 1)),
    .cnt    (to_cnt),
    .tc     (to_tc)
  );

  assign to_cnt_unused = ^to_cnt;

  assign nij_ext = SW'(nij_q);
  assign w_addr  = ADDR_W'(W_BASE + ROW * int'(kij_cnt) + int'(step_cnt));
  assign a_addr  = ADDR_W'(A_BASE + int'(step_cnt));
  assign o_addr  = ADDR_W'(O_BASE + int'(step_cnt));

  always_comb begin
    state_d   = state_q;
    gap_d     = 1'b0;
    inst_d    = IDLE_INST;
    // l0 write lands one cycle after every xmem read
    inst_d[B_L0_WR] = ~inst_q[B_CEN_X];
    mode_d    = mode_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    nij_d     = nij_q;
    nkij_d    = nkij_q;
    step_ld   = 1'b0;
    step_en   = 1'b0;
    step_last = '0;
    kij_ld    = 1'b0;
    kij_en    = 1'b0;
    to_ld     = 1'b0;
    to_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          mode_d  = cfg_mode;
          nij_d   = cfg_nij;
          nkij_d  = cfg_kij;
          err_d   = 1'b0;
          sel_d   = 1'b0;
          busy_d  = 1'b1;
          kij_ld  = 1'b1;
          step_ld = 1'b1;
          if (cfg_nij == '0 || cfg_kij == 4'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_W_RD;
          end
        end
      end
      S_W_RD: begin
        step_last = SW'(ROW - 1);
        step_en   = 1'b1;
        inst_d[B_CEN_X] = 1'b0;
        inst_d[B_AX_LO +: ADDR_W] = w_addr;
        if (step_tc) begin
          step_ld = 1'b1;
          gap_d   = 1'b1;
          state_d = S_W_LD;
        end
      end
      S_W_LD: begin
        step_last = SW'(ROW + COL - 1);
        if (!gap_q) begin
          step_en = 1'b1;
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_LOAD]  = 1'b1;
          if (step_tc) begin
            step_ld = 1'b1;
            gap_d   = 1'b1;
            state_d = S_A_RD;
          end
        end
      end
      S_A_RD: begin
        step_last = nij_ext - SW'(1);
        if (!gap_q) begin
          step_en = 1'b1;
          inst_d[B_CEN_X] = 1'b0;
          inst_d[B_AX_LO +: ADDR_W] = a_addr;
          if (step_tc) begin
            step_ld = 1'b1;
            gap_d   = 1'b1;
            state_d = S_A_EX;
          end
        end
      end
      S_A_EX: begin
        step_last = nij_ext + SW'(COL) - SW'(1);
        if (!gap_q) begin
          step_en = 1'b1;
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_EXEC]  = 1'b1;
          if (step_tc) begin
            step_ld = 1'b1;
            to_ld   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        to_en = 1'b1;
        if (ofifo_valid) begin
          state_d = S_O_WR;
        end else if (to_tc) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_O_WR: begin
        step_last = nij_ext - SW'(1);
        // a dropped ofifo_valid stalls with j held
        if (ofifo_valid) begin
          step_en = 1'b1;
          inst_d[B_ACC]      = (kij_cnt != 4'd0);
          inst_d[B_CEN_P]    = 1'b0;
          inst_d[B_WEN_P]    = 1'b0;
          inst_d[B_OFIFO_RD] = 1'b1;
          inst_d[B_AP_LO +: ADDR_W] = o_addr;
          if (step_tc) begin
            step_ld = 1'b1;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (kij_tc) begin
          state_d = S_FIN;
        end else begin
          kij_en  = 1'b1;
          sel_d   = ~sel_q;
          state_d = S_W_RD;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= 1'b0;
      inst_q  <= IDLE_INST;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nij_q   <= '0;
      nkij_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      inst_q  <= inst_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nij_q   <= nij_d;
      nkij_q  <= nkij_d;
    end
  end

  assign inst    = inst_q;
  assign mode    = mode_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign kij_idx = kij_cnt;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: scoreboard of non-idle instruction
// words plus directed checks of stall, timeout and reset.
module tb_core_seq_ctrl;

  localparam int ROW    = 2;
  localparam int COL    = 2;
  localparam int W_BASE = 0;
  localparam int A_BASE = 1024;
  localparam int O_BASE = 0;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] cfg_nij = '0;
  logic [3:0]  cfg_kij = '0;
  logic        cfg_mode = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        mode, sel, busy, done, err;
  logic [3:0]  kij_idx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_exec = 0;
  int err_rise = 0;
  logic err_prev = 1'b0;
  logic [39:0] sb[$];
  int wr_cyc[$];

  core_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_nij     (cfg_nij),
    .cfg_kij     (cfg_kij),
    .cfg_mode    (cfg_mode),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .mode        (mode),
    .sel         (sel),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .kij_idx     (kij_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [39:0] obs;
    logic [39:0] exp;
    bit have;
    if (!reset) begin
      if (inst !== IDLE) begin
        obs = {mode, sel, kij_idx, inst};
        have = (sb.size() != 0);
        exp = '0;
        if (have) exp = sb.pop_front();
        tests++;
        assert (have && obs === exp) else begin
          fails++;
          $error("FAIL word: actual=%h required=%h (have=%0d)",
                 obs, exp, have);
        end
        if (inst[32] == 1'b0) wr_cyc.push_back(cyc);
        if (inst[1]) last_exec = cyc;
      end
      if (err && !err_prev) err_rise = cyc;
      if (done) done_cnt++;
    end
    err_prev = err;
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    assert (act === req) else begin
      fails++;
      $error("FAIL %s: actual=%0h required=%0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic m, input int k, input logic [33:0] w);
    logic [3:0] kk;
    kk = 4'(k);
    sb.push_back({m, kk[0], kk, w});
  endtask

  task automatic push_layer(input int nij, input int nk, input logic m,
                            input bit wr);
    logic [33:0] w;
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i < ROW; i++) begin
        w = IDLE;
        w[19] = 1'b0;
        w[17:7] = 11'(W_BASE + k * ROW + i);
        w[2] = (i > 0);
        push(m, k, w);
      end
      w = IDLE; w[2] = 1'b1; push(m, k, w);
      for (int i = 0; i < ROW + COL; i++) begin
        w = IDLE; w[3] = 1'b1; w[0] = 1'b1; push(m, k, w);
      end
      for (int j = 0; j < nij; j++) begin
        w = IDLE;
        w[19] = 1'b0;
        w[17:7] = 11'(A_BASE + j);
        w[2] = (j > 0);
        push(m, k, w);
      end
      w = IDLE; w[2] = 1'b1; push(m, k, w);
      for (int j = 0; j < nij + COL; j++) begin
        w = IDLE; w[3] = 1'b1; w[1] = 1'b1; push(m, k, w);
      end
      if (!wr) return;
      for (int j = 0; j < nij; j++) begin
        w = IDLE;
        w[33] = (k != 0);
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = 11'(O_BASE + j);
        w[6] = 1'b1;
        push(m, k, w);
      end
    end
  endtask

  task automatic start_layer(input int nij, input int nk, input logic m);
    cfg_nij = 11'(nij);
    cfg_kij = 4'(nk);
    cfg_mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < budget);
    tests++;
    assert (done === 1'b1) else begin
      fails++;
      $error("FAIL %s: done actual=%0b required=1", tag, done);
    end
  endtask

  initial begin
    int d0;
    int n;

    repeat (3) tick();
    chk("rst_inst", inst, IDLE);
    chk("rst_mode", mode, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kij", kij_idx, 0);
    reset = 1'b0;
    tick();

    // single kernel position, full layer
    ofifo_valid = 1'b1;
    push_layer(4, 1, 1'b0, 1'b1);
    d0 = done_cnt;
    start_layer(4, 1, 1'b0);
    chk("t1_busy", busy, 1);
    wait_done(400, "t1_done");
    chk("t1_busy_end", busy, 0);
    chk("t1_sb", sb.size(), 0);
    // start coinciding with done is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_start_on_done", busy, 0);
    repeat (5) tick();
    chk("t1_one_done", done_cnt - d0, 1);

    // three kernel positions, sel/acc ping-pong, busy start ignored
    push_layer(3, 3, 1'b1, 1'b1);
    d0 = done_cnt;
    start_layer(3, 3, 1'b1);
    repeat (8) tick();
    start_layer(1, 1, 1'b0);
    wait_done(800, "t2_done");
    repeat (5) tick();
    chk("t2_sb", sb.size(), 0);
    chk("t2_one_done", done_cnt - d0, 1);
    chk("t2_mode", mode, 1);

    // ofifo_valid drops for 3 cycles mid drain
    push_layer(4, 1, 1'b0, 1'b1);
    wr_cyc.delete();
    start_layer(4, 1, 1'b0);
    n = 0;
    while (wr_cyc.size() < 2 && n < 300) begin
      tick();
      n++;
    end
    chk("t3_wr2_seen", wr_cyc.size() >= 2, 1);
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    ofifo_valid = 1'b1;
    wait_done(300, "t3_done");
    chk("t3_sb", sb.size(), 0);
    chk("t3_nwr", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      chk("t3_gap01", wr_cyc[1] - wr_cyc[0], 1);
      chk("t3_stall", wr_cyc[2] - wr_cyc[1], 4);
      chk("t3_gap23", wr_cyc[3] - wr_cyc[2], 1);
    end
    repeat (3) tick();

    // drain timeout
    ofifo_valid = 1'b0;
    push_layer(4, 1, 1'b0, 1'b0);
    start_layer(4, 1, 1'b0);
    wait_done(400, "t4_done");
    chk("t4_err", err, 1);
    chk("t4_to_len", err_rise - last_exec, 64);
    chk("t4_sb", sb.size(), 0);
    repeat (2) tick();
    chk("t4_err_sticky", err, 1);

    // empty layer: clears err, done two cycles after start
    ofifo_valid = 1'b1;
    start_layer(0, 2, 1'b0);
    chk("t6_err_clr", err, 0);
    chk("t6_busy", busy, 1);
    chk("t6_nodone", done, 0);
    tick();
    chk("t6_done", done, 1);
    chk("t6_busy_end", busy, 0);
    chk("t6_inst", inst, IDLE);
    repeat (3) tick();

    // reset in the middle of execute
    push_layer(4, 1, 1'b0, 1'b1);
    start_layer(4, 1, 1'b0);
    n = 0;
    while (inst[1] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_exec_seen", inst[1], 1);
    sb.delete();
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk("t5_inst", inst, 34'h18_00C_0000);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("t5_nodone", done_cnt - d0, 0);
    chk("t5_idle", inst, IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
